// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state encodings
// and the default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // The unused code 2'd3 falls into the FSM default branch and recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Full-adder cell built from two half adders; the second one folds in the carry.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s1;
    logic c1;
    logic c2;

    half_adder u_ha0 (
        .a (a),
        .b (b),
        .s (s1),
        .c (c1)
    );

    half_adder u_ha1 (
        .a (s1),
        .b (cin),
        .s (s),
        .c (c2)
    );

    assign cout = c1 | c2;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder, the building block of the full-adder cell.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell reused over WIDTH cycles,
// LSB first, framed by a start/busy/done handshake.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic fa_s;
    logic fa_cout;

    full_adder u_fa (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Subtraction is A + ~B + 1, the +1 entering as the initial carry.
                    a_sr_d  = a;
                    b_sr_d  = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d   = {fa_s, acc_q[WIDTH-1:1]};
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                carry_d = fa_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    // carry_q is the carry into the MSB on this final cycle.
                    sum_d   = {fa_s, acc_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
                    ovf_d   = carry_q ^ fa_cout;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder: an 8-bit instance for the main scenarios
// and a 2-bit instance for the narrow-width corner.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       sub = 1'b0;
    logic       busy, done, cout, ovf;
    logic [7:0] sum;

    logic       start2 = 1'b0;
    logic [1:0] a2 = '0;
    logic [1:0] b2 = '0;
    logic       sub2 = 1'b0;
    logic       busy2, done2, cout2, ovf2;
    logic [1:0] sum2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut (
        .clk (clk), .rst_n (rst_n), .start (start), .a (a), .b (b), .sub (sub),
        .busy (busy), .done (done), .sum (sum), .cout (cout), .ovf (ovf)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk (clk), .rst_n (rst_n), .start (start2), .a (a2), .b (b2), .sub (sub2),
        .busy (busy2), .done (done2), .sum (sum2), .cout (cout2), .ovf (ovf2)
    );

    // Launch one 8-bit operation and wait (bounded) for its done pulse.
    task automatic do_op(input logic [7:0] aa, input logic [7:0] bb, input logic s,
                         output int nbusy, output bit got);
        @(negedge clk);
        a = aa; b = bb; sub = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nbusy = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (done) got = 1'b1;
            else begin
                if (busy) nbusy++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if ({busy, done, cout, ovf} !== 4'b0) begin n_bad++;
            $display("FAIL reset_flags: got busy/done/cout/ovf=%b want 0000", {busy, done, cout, ovf}); end
        n_cmp++; if (sum !== 8'h00) begin n_bad++;
            $display("FAIL reset_sum: got %h want 00", sum); end
        n_cmp++; if ({busy2, done2, sum2, cout2, ovf2} !== 6'b0) begin n_bad++;
            $display("FAIL reset_w2: got %b want 000000", {busy2, done2, sum2, cout2, ovf2}); end
        rst_n = 1'b1;
    endtask

    task automatic test_arith();
        logic [7:0] va [5] = '{8'd100, 8'd127, 8'd255, 8'd5,  8'h80};
        logic [7:0] vb [5] = '{8'd27,  8'd1,   8'd1,   8'd7,  8'h01};
        logic       vs [5] = '{1'b0,   1'b0,   1'b0,   1'b1,  1'b1};
        logic [7:0] es [5] = '{8'd127, 8'h80,  8'h00,  8'hFE, 8'h7F};
        logic       ec [5] = '{1'b0,   1'b0,   1'b1,   1'b0,  1'b1};
        logic       eo [5] = '{1'b0,   1'b1,   1'b0,   1'b0,  1'b1};
        int nbusy;
        bit got;
        for (int v = 0; v < 5; v++) begin
            do_op(va[v], vb[v], vs[v], nbusy, got);
            n_cmp++; if (!got) begin n_bad++;
                $display("FAIL arith%0d_done: no done pulse within 40 cycles", v); end
            n_cmp++; if (nbusy != 8) begin n_bad++;
                $display("FAIL arith%0d_busy: got %0d busy cycles want 8", v, nbusy); end
            n_cmp++; if ({sum, cout, ovf} !== {es[v], ec[v], eo[v]}) begin n_bad++;
                $display("FAIL arith%0d %0d%s%0d: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                         v, va[v], vs[v] ? "-" : "+", vb[v], sum, cout, ovf, es[v], ec[v], eo[v]); end
            @(negedge clk);
            n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++;
                $display("FAIL arith%0d_pulse: got done=%b busy=%b one cycle later want 0 0", v, done, busy); end
        end
    endtask

    // Disturb start/a/b/sub mid-run; the latched operands must win.
    task automatic test_midrun();
        int  nbusy = 0;
        bit  got = 1'b0;
        @(negedge clk);
        a = 8'd10; b = 8'd20; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (i == 2) begin start = 1'b1; a = 8'h01; b = 8'h01; sub = 1'b1; end
            if (i == 3) start = 1'b0;
            if (i == 4) begin
                n_cmp++; if (sum !== 8'h7F) begin n_bad++;
                    $display("FAIL midrun_hold: got sum=%h mid-run want 7f", sum); end
            end
            if (done) got = 1'b1;
            else begin
                if (busy) nbusy++;
                @(negedge clk);
            end
        end
        n_cmp++; if (!got || nbusy != 8) begin n_bad++;
            $display("FAIL midrun_busy: got done=%b busy cycles=%0d want 1 8", got, nbusy); end
        n_cmp++; if ({sum, cout, ovf} !== {8'd30, 1'b0, 1'b0}) begin n_bad++;
            $display("FAIL midrun_result: got sum=%h cout=%b ovf=%b want 1e 0 0", sum, cout, ovf); end
        nbusy = 0;
        repeat (4) begin @(negedge clk); if (busy) nbusy++; end
        n_cmp++; if (nbusy != 0) begin n_bad++;
            $display("FAIL midrun_restart: got %0d busy cycles after done want 0", nbusy); end
    endtask

    task automatic test_reset_midrun();
        int nbusy = 0;
        int ndone = 0;
        bit got;
        @(negedge clk);
        a = 8'd50; b = 8'd60; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({busy, done, sum, cout, ovf} !== 11'b0) begin n_bad++;
            $display("FAIL abort_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                     busy, done, sum, cout, ovf); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin @(negedge clk); if (done) ndone++; if (busy) nbusy++; end
        n_cmp++; if (ndone != 0 || nbusy != 0) begin n_bad++;
            $display("FAIL abort_idle: got done=%0d busy=%0d cycles after reset want 0 0", ndone, nbusy); end
        do_op(8'd3, 8'd4, 1'b0, nbusy, got);
        n_cmp++; if (!got || sum !== 8'd7 || nbusy != 8) begin n_bad++;
            $display("FAIL abort_restart: got done=%b sum=%h busy=%0d want 1 07 8", got, sum, nbusy); end
    endtask

    // With start held high, acceptance at edge 1 puts done at samples 8,18,28,38.
    task automatic test_held();
        int npulse = 0;
        int last = -1;
        @(negedge clk);
        a = 8'd1; b = 8'd2; sub = 1'b0; start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                n_cmp++;
                if ((last < 0 && i != 8) || (last >= 0 && i - last != 10)) begin n_bad++;
                    $display("FAIL held_spacing: got done at sample %0d (previous %0d) want 8 + 10*n", i, last); end
                npulse++;
                last = i;
            end
        end
        start = 1'b0;
        n_cmp++; if (npulse != 4 || sum !== 8'd3) begin n_bad++;
            $display("FAIL held_count: got %0d pulses sum=%h want 4 03", npulse, sum); end
    endtask

    task automatic test_width2();
        logic [1:0] va [2] = '{2'd3, 2'd1};
        logic [1:0] vb [2] = '{2'd1, 2'd2};
        logic       vs [2] = '{1'b0, 1'b1};
        logic [3:0] exp [2] = '{{2'd0, 1'b1, 1'b0}, {2'd3, 1'b0, 1'b1}};
        for (int v = 0; v < 2; v++) begin
            int  nbusy = 0;
            bit  got = 1'b0;
            @(negedge clk);
            a2 = va[v]; b2 = vb[v]; sub2 = vs[v]; start2 = 1'b1;
            @(negedge clk);
            start2 = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                if (done2) got = 1'b1;
                else begin
                    if (busy2) nbusy++;
                    @(negedge clk);
                end
            end
            n_cmp++; if (!got || nbusy != 2) begin n_bad++;
                $display("FAIL w2_%0d_busy: got done=%b busy cycles=%0d want 1 2", v, got, nbusy); end
            n_cmp++; if ({sum2, cout2, ovf2} !== exp[v]) begin n_bad++;
                $display("FAIL w2_%0d_result: got sum/cout/ovf=%b want %b", v, {sum2, cout2, ovf2}, exp[v]); end
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_midrun();
        test_reset_midrun();
        test_held();
        test_width2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
